// File: rtl/manchester_tx_arbiter_pkg.sv
// Shared definitions for the Manchester TX link arbiter: FSM encoding,
// source-ID width and the default header base byte.
package manchester_tx_arbiter_pkg;

    localparam int         SRC_ID_W     = 3;
    localparam int         MAX_SRC      = 8;
    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

endpackage

// File: rtl/manchester_tx_arbiter_if.sv
// AXI-Stream bundle between NUM_SRC byte sources, the arbiter and the link.
// The master modport is the arbiter's view; slave is the sources/link side.
interface manchester_tx_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]            s_axis_tvalid;
    logic [NUM_SRC-1:0]            s_axis_tlast;
    logic [NUM_SRC-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/manchester_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
    import manchester_tx_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   last_grant_i,
    output logic [SRC_W-1:0]   grant_o,
    output logic               any_req_o
);

    int idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_o = '0;
        idx     = 0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = int'(last_grant_i) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (req_i[SRC_W'(idx)]) grant_o = SRC_W'(idx);
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/manchester_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Manchester TX link between
// NUM_SRC byte sources; prepends a source-ID header and enforces MAX_LEN/gap.
//
//   state | meaning
//   IDLE  | waiting for any source; picks next source round-robin
//   HDR   | presenting header byte HDR_BASE|grant_id
//   DATA  | pass-through of granted source
//   DRAIN | discarding remainder of a truncated packet
//   GAP   | inter-frame idle gap
module manchester_tx_arbiter
    import manchester_tx_arbiter_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter int         DATA_WIDTH = 8,
    parameter int         GAP_CYCLES = 16,
    parameter int         MAX_LEN    = 255,
    parameter logic [7:0] HDR_BASE   = HDR_BASE_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    manchester_tx_arbiter_if.master bus,
    output logic [SRC_ID_W-1:0]    grant_id,
    output logic                   busy,
    output logic                   trunc_err
);

    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW       = $clog2(MAX_LEN + 1);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e                state_q, state_d, end_state;
    logic [SRC_ID_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]      last_q, last_d, pick, gidx;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  trunc_q, trunc_d;
    logic                  any_req, src_valid, src_last, at_max;
    logic [DATA_WIDTH-1:0] src_data, m_tdata;
    logic [NUM_SRC-1:0]    s_tready;
    logic                  m_tvalid, m_tlast;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req_i        (bus.s_axis_tvalid),
        .last_grant_i (last_q),
        .grant_o      (pick),
        .any_req_o    (any_req)
    );

    assign gidx      = grant_q[SRC_W-1:0];
    assign src_valid = bus.s_axis_tvalid[gidx];
    assign src_last  = bus.s_axis_tlast[gidx];
    assign src_data  = bus.s_axis_tdata[DATA_WIDTH*gidx +: DATA_WIDTH];
    assign at_max    = (cnt_q == CW'(MAX_LEN - 1));
    assign end_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        trunc_d  = 1'b0;
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = SRC_ID_W'(pick);
                    last_d  = pick;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = HDR_BASE | DATA_WIDTH'(grant_q);
                if (bus.m_axis_tready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_tvalid       = src_valid;
                m_tdata        = src_data;
                m_tlast        = src_last | at_max;
                s_tready[gidx] = bus.m_axis_tready;
                if (src_valid && bus.m_axis_tready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (src_last) begin
                        gap_d   = GW'(GAP_LOAD);
                        state_d = end_state;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s_tready[gidx] = 1'b1;
                if (src_valid && src_last) begin
                    gap_d   = GW'(GAP_LOAD);
                    state_d = end_state;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.s_axis_tready = s_tready;
    assign bus.m_axis_tdata  = m_tdata;
    assign bus.m_axis_tvalid = m_tvalid;
    assign bus.m_axis_tlast  = m_tlast;
    assign grant_id          = grant_q;
    assign busy              = (state_q != ST_IDLE);
    assign trunc_err         = trunc_q;

endmodule
